// File: rtl/mul_div.sv
// Radix-2 iterative multiply/divide unit: one shift-add or restoring-subtract step per clock.
// MUL returns the full 2*XLEN product; DIV returns {quotient, remainder}.
module mul_div #(
  parameter int XLEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                annul_i,
  input  logic                mul_or_div_i,
  input  logic [XLEN-1:0]     dividend_i,
  input  logic [XLEN-1:0]     divisor_i,
  input  logic                reg1_sign_i,
  input  logic                reg2_sign_i,
  output logic [2*XLEN-1:0]   result_o,
  output logic                done_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state, state_next;
  logic                is_div, is_div_next;
  logic                neg_q, neg_q_next;
  logic                neg_r, neg_r_next;
  logic [XLEN-1:0]     opa, opa_next;
  logic [XLEN-1:0]     opb, opb_next;
  logic [2*XLEN:0]     acc, acc_next;
  logic [CW-1:0]       cnt, cnt_next;
  logic [2*XLEN-1:0]   result_next;
  logic                done_next;

  logic [XLEN:0]       mul_sum;
  logic [XLEN+1:0]     diff;
  logic [2*XLEN:0]     mul_step, div_step, step;
  logic [XLEN-1:0]     q_mag, r_mag;
  logic [2*XLEN-1:0]   fixed;
  logic [XLEN-1:0]     mag_a, mag_b;

  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] x, input logic s);
    return (s && x[XLEN-1]) ? -x : x;
  endfunction

  assign mag_a = magnitude(dividend_i, reg1_sign_i);
  assign mag_b = magnitude(divisor_i, reg2_sign_i);

  // Multiply: acc = {carry, high partial product, remaining multiplier bits}.
  // Divide: acc = {partial remainder, dividend bits / quotient bits}; diff is the trial on (acc << 1).
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opa};
    mul_step = {1'b0, (acc[0] ? mul_sum : {1'b0, acc[2*XLEN-1:XLEN]}), acc[XLEN-1:1]};
    diff     = acc[2*XLEN:XLEN-1] - {2'b00, opb};
    div_step = diff[XLEN+1] ? {acc[2*XLEN-1:0], 1'b0}
                            : {diff[XLEN:0], acc[XLEN-2:0], 1'b1};
    step     = is_div ? div_step : mul_step;
    q_mag    = step[XLEN-1:0];
    r_mag    = step[2*XLEN-1:XLEN];
    if (is_div)
      fixed = {(neg_q ? -q_mag : q_mag), (neg_r ? -r_mag : r_mag)};
    else
      fixed = neg_q ? -step[2*XLEN-1:0] : step[2*XLEN-1:0];
  end

  always_comb begin
    state_next  = state;
    is_div_next = is_div;
    neg_q_next  = neg_q;
    neg_r_next  = neg_r;
    opa_next    = opa;
    opb_next    = opb;
    acc_next    = acc;
    cnt_next    = cnt;
    result_next = result_o;
    done_next   = 1'b0;
    case (state)
      IDLE: begin
        if (start_i && !annul_i) begin
          is_div_next = mul_or_div_i;
          neg_q_next  = (reg1_sign_i & dividend_i[XLEN-1]) ^ (reg2_sign_i & divisor_i[XLEN-1]);
          neg_r_next  = reg1_sign_i & dividend_i[XLEN-1];
          opa_next    = mag_a;
          opb_next    = mag_b;
          cnt_next    = '0;
          if (mul_or_div_i && divisor_i == '0) begin
            result_next = {{XLEN{1'b1}}, dividend_i};
            state_next  = DONE;
          end else begin
            acc_next   = {{(XLEN+1){1'b0}}, (mul_or_div_i ? mag_a : mag_b)};
            state_next = CALC;
          end
        end
      end
      CALC: begin
        if (annul_i || !start_i) begin
          state_next = IDLE;
        end else begin
          acc_next = step;
          cnt_next = cnt + 1'b1;
          if (cnt == LAST) begin
            result_next = fixed;
            state_next  = DONE;
          end
        end
      end
      DONE: begin
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      opa      <= '0;
      opb      <= '0;
      acc      <= '0;
      cnt      <= '0;
      result_o <= '0;
      done_o   <= 1'b0;
    end else begin
      state    <= state_next;
      is_div   <= is_div_next;
      neg_q    <= neg_q_next;
      neg_r    <= neg_r_next;
      opa      <= opa_next;
      opb      <= opb_next;
      acc      <= acc_next;
      cnt      <= cnt_next;
      result_o <= result_next;
      done_o   <= done_next;
    end
  end

endmodule

// File: tb/tb_mul_div.sv
// Scoreboard bench for mul_div: driver pushes expected result and completion cycle,
// monitor pops and compares on every done_o pulse.
module tb_mul_div;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic        mul_or_div_i = 1'b0;
  logic [31:0] dividend_i = '0;
  logic [31:0] divisor_i = '0;
  logic        reg1_sign_i = 1'b0;
  logic        reg2_sign_i = 1'b0;
  logic [63:0] result_o;
  logic        done_o;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [63:0] res;
    int          at;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  mul_div #(.XLEN(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .mul_or_div_i (mul_or_div_i),
    .dividend_i   (dividend_i),
    .divisor_i    (divisor_i),
    .reg1_sign_i  (reg1_sign_i),
    .reg2_sign_i  (reg2_sign_i),
    .result_o     (result_o),
    .done_o       (done_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Monitor: every done pulse must match the head of the scoreboard.
  always begin
    @(posedge clk);
    #1;
    if (done_o === 1'b1) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: got done_o=1 at cycle %0d, expected 0", cyc);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, "_result"}, result_o, mon_e.res);
        check({mon_e.name, "_cycle"}, 64'(cyc), 64'(mon_e.at));
      end
    end
  end

  task automatic run_op(input string name, input bit md, input logic [31:0] a, input logic [31:0] b,
                        input bit s1, input bit s2, input logic [63:0] exp_res, input int lat);
    bit seen;
    exp_t e;
    @(negedge clk);
    mul_or_div_i = md;
    dividend_i   = a;
    divisor_i    = b;
    reg1_sign_i  = s1;
    reg2_sign_i  = s2;
    start_i      = 1'b1;
    e.res  = exp_res;
    e.at   = cyc + lat;
    e.name = name;
    sb.push_back(e);
    @(posedge clk);
    #2;
    // Operands are latched; scrambling them afterwards must not matter.
    dividend_i = $urandom;
    divisor_i  = $urandom;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done_o === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #2;
    end
    start_i = 1'b0;
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: got no done_o in 100 cycles, expected done_o", name);
      sb.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation time limit, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    check("reset_done", 64'(done_o), 64'd0);
    check("reset_result", result_o, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    run_op("mulu",   1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 1'b0, 1'b0, 64'h0000_0006_FFFF_FFEB, 34);
    run_op("mulh",   1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 34);
    run_op("mulhsu", 1'b0, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 34);
    run_op("mulu_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'hFFFF_FFFE_0000_0001, 34);
    run_op("div",    1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 1'b1, 64'hFFFF_FFFD_FFFF_FFFF, 34);
    run_op("divu",   1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b0, 64'h7FFF_FFFC_0000_0001, 34);
    run_op("div_negb", 1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 1'b1, 1'b1, 64'hFFFF_FFFD_0000_0001, 34);
    run_op("div0",   1'b1, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b1, 64'hFFFF_FFFF_0000_0005, 2);
    run_op("ovf",    1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 64'h8000_0000_0000_0000, 34);

    // Abort: annul at CALC iteration 10, no completion, result holds.
    @(negedge clk);
    mul_or_div_i = 1'b1;
    dividend_i   = 32'd100;
    divisor_i    = 32'd7;
    reg1_sign_i  = 1'b0;
    reg2_sign_i  = 1'b0;
    start_i      = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0;
    start_i = 1'b0;
    check("abort_result_held", result_o, 64'h8000_0000_0000_0000);
    run_op("mul_after_abort", 1'b0, 32'd3, 32'd4, 1'b0, 1'b0, 64'h0000_0000_0000_000C, 34);
    repeat (30) @(posedge clk);
    #1;
    check("abort_quiet_result", result_o, 64'h0000_0000_0000_000C);

    // Asynchronous reset mid-CALC, off the clock edge.
    @(negedge clk);
    mul_or_div_i = 1'b0;
    dividend_i   = 32'h1234_5678;
    divisor_i    = 32'h9ABC_DEF0;
    start_i      = 1'b1;
    repeat (15) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("async_rst_done", 64'(done_o), 64'd0);
    check("async_rst_result", result_o, 64'd0);
    start_i = 1'b0;
    #7;
    rst = 1'b1;
    run_op("divu_after_rst", 1'b1, 32'd100, 32'd7, 1'b0, 1'b0, 64'h0000_000E_0000_0002, 34);

    repeat (5) @(posedge clk);
    #3;
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
